tiled_image_writer: RTL



---
 rtl/tiled_image_writer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tiled_image_writer.sv
// Writes square pixel tables into a raster-ordered image RAM, one block at a time,
// walking blocks left-to-right then top-to-bottom across the frame.
module tiled_image_writer #(
  parameter int unsigned IMAGE_WIDTH     = 320,
  parameter int unsigned IMAGE_HEIGHT    = 240,
  parameter int unsigned PIXEL_WIDTH     = 8,
  parameter int unsigned CHANNELS        = 3,
  parameter int unsigned TABLE_EDGE_SIZE = 8,
  localparam int unsigned E2   = TABLE_EDGE_SIZE * TABLE_EDGE_SIZE,
  localparam int unsigned BlkW = IMAGE_WIDTH / TABLE_EDGE_SIZE,
  localparam int unsigned BlkH = IMAGE_HEIGHT / TABLE_EDGE_SIZE,
  localparam int unsigned BW   = (BlkW > 1) ? $clog2(BlkW) : 1,
  localparam int unsigned BH   = (BlkH > 1) ? $clog2(BlkH) : 1,
  localparam int unsigned AW   = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  localparam int unsigned TW   = (TABLE_EDGE_SIZE > 1) ? $clog2(TABLE_EDGE_SIZE) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CHANNELS*E2*PIXEL_WIDTH-1:0]    table_data,
  input  logic                                  table_valid,
  output logic                                  table_ready,
  input  logic                                  frame_restart,
  output logic [AW-1:0]                         ram_address,
  output logic [CHANNELS*PIXEL_WIDTH-1:0]       ram_data,
  output logic                                  ram_ce,
  output logic                                  ram_we,
  input  logic                                  ram_ready,
  output logic                                  block_done,
  output logic                                  frame_done,
  output logic [BW-1:0]                         decoded_width_block_index,
  output logic [BH-1:0]                         decoded_height_block_index,
  output logic                                  busy
);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e                               state_q, state_d;
  logic [TW-1:0]                        tx_q, tx_d, ty_q, ty_d;
  logic [BW-1:0]                        bw_q, bw_d, dec_w_q, dec_w_d;
  logic [BH-1:0]                        bh_q, bh_d, dec_h_q, dec_h_d;
  logic                                 block_done_q, block_done_d;
  logic                                 frame_done_q, frame_done_d;
  logic                                 table_load;
  logic [CHANNELS*E2*PIXEL_WIDTH-1:0]   table_q;
  logic [AW-1:0]                        row, col;
  int unsigned                          pix;

  assign table_ready = (state_q == StIdle) && !frame_restart;
  assign busy        = (state_q == StWrite);
  assign block_done  = block_done_q;
  assign frame_done  = frame_done_q;
  assign decoded_width_block_index  = dec_w_q;
  assign decoded_height_block_index = dec_h_q;

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    bw_d         = bw_q;
    bh_d         = bh_q;
    dec_w_d      = dec_w_q;
    dec_h_d      = dec_h_q;
    block_done_d = 1'b0;
    frame_done_d = 1'b0;
    table_load   = 1'b0;
    case (state_q)
      StIdle: begin
        if (table_valid && table_ready) begin
          table_load = 1'b1;
          tx_d       = '0;
          ty_d       = '0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        // Position only advances on an accepted write, so stalls never skip pixels.
        if (ram_ready) begin
          if (tx_q == TW'(TABLE_EDGE_SIZE - 1)) begin
            tx_d = '0;
            if (ty_q == TW'(TABLE_EDGE_SIZE - 1)) begin
              ty_d         = '0;
              state_d      = StIdle;
              block_done_d = 1'b1;
              dec_w_d      = bw_q;
              dec_h_d      = bh_q;
              if (bw_q == BW'(BlkW - 1)) begin
                bw_d = '0;
                if (bh_q == BH'(BlkH - 1)) begin
                  bh_d         = '0;
                  frame_done_d = 1'b1;
                end else begin
                  bh_d = bh_q + 1'b1;
                end
              end else begin
                bw_d = bw_q + 1'b1;
              end
            end else begin
              ty_d = ty_q + 1'b1;
            end
          end else begin
            tx_d = tx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort keeps the last decoded indices but drops all position state.
    if (frame_restart) begin
      state_d      = StIdle;
      tx_d         = '0;
      ty_d         = '0;
      bw_d         = '0;
      bh_d         = '0;
      block_done_d = 1'b0;
      frame_done_d = 1'b0;
      table_load   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      tx_q         <= '0;
      ty_q         <= '0;
      bw_q         <= '0;
      bh_q         <= '0;
      dec_w_q      <= '0;
      dec_h_q      <= '0;
      block_done_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      bw_q         <= bw_d;
      bh_q         <= bh_d;
      dec_w_q      <= dec_w_d;
      dec_h_q      <= dec_h_d;
      block_done_q <= block_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffer contents are only visible in WRITE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (table_load) begin
      table_q <= table_data;
    end
  end

  always_comb begin
    ram_ce      = 1'b0;
    ram_we      = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    row         = '0;
    col         = '0;
    pix         = 32'(ty_q) * TABLE_EDGE_SIZE + 32'(tx_q);
    if (state_q == StWrite) begin
      ram_ce      = 1'b1;
      ram_we      = 1'b1;
      row         = AW'(bh_q) * AW'(TABLE_EDGE_SIZE) + AW'(ty_q);
      col         = AW'(bw_q) * AW'(TABLE_EDGE_SIZE) + AW'(tx_q);
      ram_address = row * AW'(IMAGE_WIDTH) + col;
      for (int c = 0; c < CHANNELS; c++) begin
        ram_data[c*PIXEL_WIDTH +: PIXEL_WIDTH] = table_q[(c*E2 + pix)*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
  end

endmodule
